sobel_stream_core: RTL and testbench

- Parametrised, streaming successor to the frame-at-a-time Sobel system.
- Accepts a raster-order pixel stream over a valid/ready handshake and buffers two image rows internally, so it needs no full-frame memory.
- Emits the (IMG_W-2)x(IMG_H-2) Sobel result stream, selectable per frame as saturated magnitude or binary threshold.
- Reports done and a per-frame cycle count. Sits between the pixel source (memory reader/camera) and the output sink.

---
 rtl/sobel_stream_core.sv | 171 +++++++++++++++++
 tb/tb_sobel_stream_core.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/sobel_stream_core.sv
// Streaming 3x3 Sobel edge detector: raster pixels in, (IMG_W-2)x(IMG_H-2) results out.
// Two rotating line buffers replace a full-frame store; one output register, no skid.
module sobel_stream_core #(
    parameter int IMG_W = 240,
    parameter int IMG_H = 240,
    parameter int PIX_W = 8,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode,
    input  logic [PIX_W+2:0] thresh,
    input  logic [PIX_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [PIX_W-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] total_cycles_out
);

    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);
    localparam int SW = PIX_W + 3;
    localparam logic [XW-1:0] X_LAST  = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST  = YW'(IMG_H - 1);
    localparam logic [SW-1:0] PIX_MAX = SW'((1 << PIX_W) - 1);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t state, state_nxt;

    logic                  mode_q;
    logic [SW-1:0]         thresh_q;
    logic [XW-1:0]         x;
    logic [YW-1:0]         y;
    logic                  row_sel;
    logic                  last_in;
    logic [CNT_W-1:0]      cycle_cnt;
    logic [PIX_W-1:0]      line_a [IMG_W];
    logic [PIX_W-1:0]      line_b [IMG_W];
    logic [2:0][PIX_W-1:0] win_l;
    logic [2:0][PIX_W-1:0] win_m;

    logic                  in_fire;
    logic                  out_fire;
    logic                  emit;
    logic [PIX_W-1:0]      top;
    logic [PIX_W-1:0]      mid;
    logic [SW-1:0]         l_sum, r_sum, t_sum, b_sum;
    logic signed [SW-1:0]  gx, gy;
    logic [SW-1:0]         abs_gx, abs_gy, mag;
    logic [PIX_W-1:0]      result;

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign emit     = in_fire && (x >= XW'(2)) && (y >= YW'(2));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Input stops once the final pixel is in, so nothing is accepted while the last result drains.
    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        in_ready  = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                busy     = 1'b1;
                in_ready = !last_in && (out_ready || !out_valid);
                if (out_fire && last_in) state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // row_sel picks which buffer holds row y-1; the other holds row y-2 and is overwritten with row y.
    always_comb begin
        top = row_sel ? line_a[x] : line_b[x];
        mid = row_sel ? line_b[x] : line_a[x];
    end

    // NOTE: line buffers have no reset; rows 0-1 are always rewritten before any result reads them.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            if (row_sel) line_a[x] <= in_data;
            else         line_b[x] <= in_data;
        end
    end

    // The window is win_l (left), win_m (centre) and the incoming column {top, mid, in_data}.
    always_comb begin
        l_sum  = SW'(win_l[0]) + (SW'(win_l[1]) << 1) + SW'(win_l[2]);
        r_sum  = SW'(top) + (SW'(mid) << 1) + SW'(in_data);
        t_sum  = SW'(win_l[0]) + (SW'(win_m[0]) << 1) + SW'(top);
        b_sum  = SW'(win_l[2]) + (SW'(win_m[2]) << 1) + SW'(in_data);
        gx     = r_sum - l_sum;
        gy     = b_sum - t_sum;
        abs_gx = gx[SW-1] ? SW'(-gx) : SW'(gx);
        abs_gy = gy[SW-1] ? SW'(-gy) : SW'(gy);
        mag    = abs_gx + abs_gy;
        if (mode_q) result = (mag >= thresh_q) ? '1 : '0;
        else        result = (mag > PIX_MAX) ? '1 : mag[PIX_W-1:0];
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q           <= 1'b0;
            thresh_q         <= '0;
            x                <= '0;
            y                <= '0;
            row_sel          <= 1'b0;
            last_in          <= 1'b0;
            cycle_cnt        <= '0;
            win_l            <= '0;
            win_m            <= '0;
            out_valid        <= 1'b0;
            out_data         <= '0;
            total_cycles_out <= '0;
        end else begin
            if (state == IDLE && start) begin
                mode_q    <= mode;
                thresh_q  <= thresh;
                x         <= '0;
                y         <= '0;
                row_sel   <= 1'b0;
                last_in   <= 1'b0;
                cycle_cnt <= '0;
                win_l     <= '0;
                win_m     <= '0;
            end

            if (state == RUN && cycle_cnt != '1) cycle_cnt <= cycle_cnt + CNT_W'(1);

            if (in_fire) begin
                win_l <= win_m;
                win_m <= {in_data, mid, top};
                if (x == X_LAST) begin
                    x       <= '0;
                    y       <= y + YW'(1);
                    row_sel <= !row_sel;
                    if (y == Y_LAST) last_in <= 1'b1;
                end else begin
                    x <= x + XW'(1);
                end
            end

            if (emit) begin
                out_valid <= 1'b1;
                out_data  <= result;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (state == FIN) total_cycles_out <= cycle_cnt;
        end
    end

endmodule

// File: tb/tb_sobel_stream_core.sv
// Self-checking bench for sobel_stream_core on an 8x6 image: table vectors,
// stall/abort/restart sequences and randomized frames against a direct Sobel model.
module tb_sobel_stream_core;

    localparam int W = 8;
    localparam int H = 6;
    localparam int N = W * H;
    localparam int NRES = (W - 2) * (H - 2);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [10:0] thresh = '0;
    logic [7:0]  in_data = '0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        busy;
    logic        done;
    logic [31:0] total_cycles_out;

    int n_checks = 0;
    int n_err    = 0;

    logic [7:0] img [H][W];
    int         exp_q [$];

    typedef struct {
        int              pat;
        logic            md;
        logic [10:0]     th;
        logic [5:0][7:0] row;
        int              cyc;
    } vec_t;

    vec_t vecs [5];

    sobel_stream_core #(.IMG_W(W), .IMG_H(H), .PIX_W(8), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .thresh(thresh),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .done(done), .total_cycles_out(total_cycles_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic load_pattern(input int pat);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                case (pat)
                    0:       img[r][c] = 8'd77;
                    1:       img[r][c] = (c < 4) ? 8'd0 : 8'd100;
                    2:       img[r][c] = (c < 4) ? 8'd0 : 8'd20;
                    default: img[r][c] = 8'($urandom_range(255));
                endcase
    endtask

    function automatic int pix(input int c, input int r);
        return int'(img[r][c]);
    endfunction

    // Direct evaluation of the Sobel definition for every interior centre, raster order.
    task automatic build_model(input logic md, input logic [10:0] th);
        int gx, gy, mag;
        exp_q.delete();
        for (int cy = 1; cy < H - 1; cy++)
            for (int cx = 1; cx < W - 1; cx++) begin
                gx = (pix(cx+1, cy-1) + 2*pix(cx+1, cy) + pix(cx+1, cy+1))
                   - (pix(cx-1, cy-1) + 2*pix(cx-1, cy) + pix(cx-1, cy+1));
                gy = (pix(cx-1, cy+1) + 2*pix(cx, cy+1) + pix(cx+1, cy+1))
                   - (pix(cx-1, cy-1) + 2*pix(cx, cy-1) + pix(cx+1, cy-1));
                mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
                if (md) exp_q.push_back(mag >= int'(th) ? 255 : 0);
                else    exp_q.push_back(mag > 255 ? 255 : mag);
            end
    endtask

    task automatic load_table_expect(input vec_t v);
        exp_q.delete();
        for (int r = 0; r < H - 2; r++)
            for (int j = 0; j < W - 2; j++)
                exp_q.push_back(int'(v.row[j]));
    endtask

    // Entered and left at posedge+1. rmode: 0 always ready, 1 toggling, 2 random.
    task automatic run_frame(input logic md, input logic [10:0] th, input int vpct,
                             input int rmode, input bit poke_start, input int abort_after,
                             output int dcnt);
        int   idx, oidx, cyc;
        bit   fin, aborted, stall_prev;
        logic [7:0] stall_data;
        idx = 0; oidx = 0; dcnt = 0;
        fin = 0; aborted = 0; stall_prev = 0; stall_data = '0;
        mode = md; thresh = th; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        mode = ~md; thresh = ~th;
        for (cyc = 0; cyc < 2000 && !fin && !aborted; cyc++) begin
            in_valid  = (idx < N) && ($urandom_range(99) < vpct);
            in_data   = (idx < N) ? img[idx / W][idx % W] : 8'h00;
            out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(1));
            start     = poke_start && (cyc == 10);
            @(negedge clk);
            if (stall_prev) begin
                check("stall_valid_held", out_valid, 1);
                check("stall_data_held", out_data, stall_data);
            end
            if (done) begin
                dcnt++;
                fin = 1;
            end
            if (out_valid && out_ready) begin
                if (oidx < exp_q.size())
                    check($sformatf("result_%0d", oidx), out_data, exp_q[oidx]);
                else
                    check("extra_result", oidx, exp_q.size());
                oidx++;
            end
            stall_prev = out_valid && !out_ready;
            stall_data = out_data;
            if (in_valid && in_ready) idx++;
            if (abort_after >= 0 && idx == abort_after && in_valid && in_ready) aborted = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (!aborted) begin
            check("frame_finished", fin, 1);
            check("result_count", oidx, NRES);
            check("done_one_cycle", done, 0);
        end
    endtask

    initial begin
        int dcnt;
        int first_cyc;

        vecs[0] = '{0, 1'b0, 11'd0,   {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 49};
        vecs[1] = '{1, 1'b0, 11'd0,   {8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00}, 49};
        vecs[2] = '{2, 1'b1, 11'd64,  {8'h00, 8'h00, 8'hFF, 8'hFF, 8'h00, 8'h00}, 49};
        vecs[3] = '{2, 1'b1, 11'd100, {8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00}, 49};
        vecs[4] = '{2, 1'b0, 11'd0,   {8'h00, 8'h00, 8'h50, 8'h50, 8'h00, 8'h00}, 49};

        // Reset state
        #12;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_total", total_cycles_out, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("idle_busy", busy, 0);
        in_valid = 1'b1;
        #1;
        check("idle_in_ready", in_ready, 0);
        in_valid = 1'b0;
        @(posedge clk); #1;

        // Table vectors at full throughput
        foreach (vecs[i]) begin
            load_pattern(vecs[i].pat);
            load_table_expect(vecs[i]);
            run_frame(vecs[i].md, vecs[i].th, 100, 0, 0, -1, dcnt);
            check($sformatf("vec%0d_done_pulses", i), dcnt, 1);
            check($sformatf("vec%0d_cycles", i), total_cycles_out, vecs[i].cyc);
            check($sformatf("vec%0d_idle", i), busy, 0);
        end

        // Back-pressure and sparse input give the same step results, longer count
        load_pattern(1);
        load_table_expect(vecs[1]);
        run_frame(1'b0, 11'd0, 70, 1, 0, -1, dcnt);
        check("stall_done_pulses", dcnt, 1);
        check("stall_cycles_gt49", total_cycles_out > 32'd49, 1);

        // Mid-frame reset aborts without done and clears the count
        load_pattern(1);
        run_frame(1'b0, 11'd0, 100, 0, 0, 20, dcnt);
        check("abort_no_done", dcnt, 0);
        rst = 1'b0;
        #1;
        check("abort_total", total_cycles_out, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        load_table_expect(vecs[1]);
        run_frame(1'b0, 11'd0, 100, 0, 0, -1, dcnt);
        check("after_abort_done", dcnt, 1);
        check("after_abort_cycles", total_cycles_out, 49);

        // Start during RUN is ignored; start in the IDLE right after FIN runs an identical frame
        run_frame(1'b0, 11'd0, 100, 0, 1, -1, dcnt);
        check("poke_done", dcnt, 1);
        first_cyc = int'(total_cycles_out);
        check("poke_cycles", first_cyc, 49);
        run_frame(1'b0, 11'd0, 100, 0, 0, -1, dcnt);
        check("b2b_done", dcnt, 1);
        check("b2b_cycles_same", total_cycles_out, first_cyc);

        // Randomized images, modes and handshakes against the model
        for (int f = 0; f < 4; f++) begin
            logic        md;
            logic [10:0] th;
            md = 1'($urandom_range(1));
            th = 11'($urandom_range(1100));
            load_pattern(3);
            build_model(md, th);
            run_frame(md, th, 60 + 10 * f, 2, 0, -1, dcnt);
            check($sformatf("rand%0d_done", f), dcnt, 1);
            check($sformatf("rand%0d_cycles_ge49", f), total_cycles_out >= 32'd49, 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule
